// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: tracked-writer entry and forward-select encoding.
// Register and forward fields are stored at fixed widths (up to 256 registers, 16 stages).
package hazard_pkg;

    localparam int WSEL_W = 8;
    localparam int FWD_W  = 4;

    typedef logic [WSEL_W-1:0] wsel_t;
    typedef logic [FWD_W-1:0]  fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 4'd0;

    typedef struct packed {
        logic  valid;
        logic  wen;
        logic  load;
        wsel_t wsel;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, wen: 1'b0, load: 1'b0, wsel: 8'd0};

    function automatic logic entry_hit(input sb_entry_t e, input wsel_t rsel, input logic use_op);
        return e.valid & e.wen & (e.wsel == rsel) & (rsel != 8'd0) & use_op;
    endfunction

    // Entry index at which the producer's result can be forwarded.
    function automatic int ready_index(input logic load, input int load_ready);
        return load ? load_ready : 32'sd1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand youngest-writer search: reports a hazard or the entry to forward from.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 2
) (
    input  sb_entry_t entries [STAGES],
    input  wsel_t     rsel,
    input  logic      use_op,
    output logic      hazard,
    output fwd_sel_t  fwd
);

    logic     hazard_s;
    logic     found_s;
    fwd_sel_t fwd_s;

    // Youngest-first search; the last entry writes the register file this cycle and is skipped.
    always_comb begin
        hazard_s = 1'b0;
        found_s  = 1'b0;
        fwd_s    = FWD_RF;
        for (int i = 0; i < STAGES - 1; i++) begin
            if (!found_s && entry_hit(entries[i], rsel, use_op)) begin
                found_s = 1'b1;
                if ((i + 1) >= ready_index(entries[i].load, LOAD_READY)) begin
                    fwd_s = fwd_sel_t'(i + 1);
                end else begin
                    hazard_s = 1'b1;
                end
            end else begin
                found_s = found_s;
            end
        end
    end

    assign hazard = hazard_s;
    assign fwd    = fwd_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: tracks in-flight writers, raises stall and
// registers the EX-stage forward selects for each source operand.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      advance,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic                      issue_wen,
    input  logic                      issue_load,
    input  logic [$clog2(NREG)-1:0]   issue_wsel,
    input  logic [$clog2(NREG)-1:0]   rsel1,
    input  logic [$clog2(NREG)-1:0]   rsel2,
    input  logic                      use1,
    input  logic                      use2,
    output logic                      stall,
    output logic [$clog2(STAGES)-1:0] fwd_sel1,
    output logic [$clog2(STAGES)-1:0] fwd_sel2,
    output logic [CNT_W-1:0]          stall_count
);

    localparam int FW = $clog2(STAGES);

    sb_entry_t        entries_r [STAGES];
    logic [FW-1:0]    fwd_sel1_r;
    logic [FW-1:0]    fwd_sel2_r;
    logic [CNT_W-1:0] stall_count_r;

    logic      hazard1_s;
    logic      hazard2_s;
    fwd_sel_t  fwd1_s;
    fwd_sel_t  fwd2_s;
    logic      stall_s;
    logic      issue_en_s;
    sb_entry_t new_entry_s;

    hazard_match #(.STAGES(STAGES), .LOAD_READY(LOAD_READY)) u_match1 (
        .entries (entries_r),
        .rsel    (wsel_t'(rsel1)),
        .use_op  (use1),
        .hazard  (hazard1_s),
        .fwd     (fwd1_s)
    );

    hazard_match #(.STAGES(STAGES), .LOAD_READY(LOAD_READY)) u_match2 (
        .entries (entries_r),
        .rsel    (wsel_t'(rsel2)),
        .use_op  (use2),
        .hazard  (hazard2_s),
        .fwd     (fwd2_s)
    );

    // Flush wins over a hazard: the killed instruction never stalls the front end.
    assign stall_s     = issue_valid & ~flush & (hazard1_s | hazard2_s);
    assign issue_en_s  = issue_valid & ~stall_s & ~flush;
    assign new_entry_s = '{valid: 1'b1, wen: issue_wen, load: issue_load, wsel: wsel_t'(issue_wsel)};

    // Entry shift, forward-select capture and saturating stall counter, all gated by advance.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < STAGES; i++) begin
                entries_r[i] <= SB_BUBBLE;
            end
            fwd_sel1_r    <= {FW{1'b0}};
            fwd_sel2_r    <= {FW{1'b0}};
            stall_count_r <= {CNT_W{1'b0}};
        end else if (advance) begin
            for (int i = STAGES - 1; i > 0; i--) begin
                entries_r[i] <= entries_r[i-1];
            end
            entries_r[0] <= issue_en_s ? new_entry_s : SB_BUBBLE;
            fwd_sel1_r   <= issue_en_s ? fwd1_s[FW-1:0] : {FW{1'b0}};
            fwd_sel2_r   <= issue_en_s ? fwd2_s[FW-1:0] : {FW{1'b0}};
            if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
                stall_count_r <= stall_count_r + CNT_W'(1);
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign stall       = stall_s;
    assign fwd_sel1    = fwd_sel1_r;
    assign fwd_sel2    = fwd_sel2_r;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a second instance with a 3-bit counter covers saturation.
module tb_hazard_scoreboard;

    typedef struct {
        logic       v, wen, ld;
        logic [4:0] ws, r1, r2;
        logic       u1, u2, adv, fl;
    } stim_t;

    typedef struct {
        string       tag;
        logic        stall;
        logic [1:0]  f1, f2;
        logic [15:0] cnt;
        logic [2:0]  cnt_s;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        advance, flush, issue_valid, issue_wen, issue_load, use1, use2;
    logic [4:0]  issue_wsel, rsel1, rsel2;
    logic        stall, stall_b;
    logic [1:0]  fwd_sel1, fwd_sel2, fwd_sel1_b, fwd_sel2_b;
    logic [15:0] stall_count;
    logic [2:0]  stall_count_b;

    exp_t        exp_q [$];
    logic [15:0] cnt_exp   = 16'd0;
    logic [2:0]  cnt_exp_s = 3'd0;
    int          n_assert  = 0;
    int          n_fail    = 0;

    hazard_scoreboard dut (
        .CLK(CLK), .RST(RST), .advance(advance), .flush(flush),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_load(issue_load),
        .issue_wsel(issue_wsel), .rsel1(rsel1), .rsel2(rsel2), .use1(use1), .use2(use2),
        .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_count(stall_count)
    );

    hazard_scoreboard #(.CNT_W(3)) dut_sat (
        .CLK(CLK), .RST(RST), .advance(advance), .flush(flush),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_load(issue_load),
        .issue_wsel(issue_wsel), .rsel1(rsel1), .rsel2(rsel2), .use1(use1), .use2(use2),
        .stall(stall_b), .fwd_sel1(fwd_sel1_b), .fwd_sel2(fwd_sel2_b), .stall_count(stall_count_b)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic stim_t mk(input logic v, wen, ld, input logic [4:0] ws, r1, r2,
                                 input logic u1, u2, adv, fl);
        stim_t s;
        s.v = v; s.wen = wen; s.ld = ld; s.ws = ws; s.r1 = r1; s.r2 = r2;
        s.u1 = u1; s.u2 = u2; s.adv = adv; s.fl = fl;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        issue_valid = s.v; issue_wen = s.wen; issue_load = s.ld; issue_wsel = s.ws;
        rsel1 = s.r1; rsel2 = s.r2; use1 = s.u1; use2 = s.u2;
        advance = s.adv; flush = s.fl;
    endtask

    // Drive one decode cycle; stall is checked before the edge, registered outputs after it.
    task automatic step(input string tag, input stim_t s, input logic es,
                        input logic [1:0] ef1, input logic [1:0] ef2);
        exp_t e;
        drive(s);
        if (es && s.adv) begin
            if (cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
            if (cnt_exp_s != 3'd7) cnt_exp_s = cnt_exp_s + 3'd1;
        end
        e.tag = tag; e.stall = es; e.f1 = ef1; e.f2 = ef2; e.cnt = cnt_exp; e.cnt_s = cnt_exp_s;
        exp_q.push_back(e);
        @(negedge CLK);
        chk({tag, ".stall"}, stall, exp_q[0].stall);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ".fwd1"}, fwd_sel1, e.f1);
        chk({e.tag, ".fwd2"}, fwd_sel2, e.f2);
        chk({e.tag, ".cnt"}, stall_count, e.cnt);
        chk({e.tag, ".cnt_s"}, stall_count_b, e.cnt_s);
    endtask

    initial begin
        RST = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        chk("reset.stall", stall, 0);
        chk("reset.fwd1", fwd_sel1, 0);
        chk("reset.fwd2", fwd_sel2, 0);
        chk("reset.cnt", stall_count, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // ALU chain: add r3; sub r4,r3,r1
        step("alu_a", mk(1, 1, 0, 3, 1, 2, 1, 1, 1, 0), 0, 0, 0);
        step("alu_b", mk(1, 1, 0, 4, 3, 1, 1, 1, 1, 0), 0, 1, 0);
        // Load-use: lw r5; add r6,r5,r5
        step("lu_load", mk(1, 1, 1, 5, 2, 0, 1, 0, 1, 0), 0, 0, 0);
        step("lu_stall", mk(1, 1, 0, 6, 5, 5, 1, 1, 1, 0), 1, 0, 0);
        step("lu_fwd", mk(1, 1, 0, 6, 5, 5, 1, 1, 1, 0), 0, 2, 2);
        // Youngest writer of r7 wins
        step("yng_w1", mk(1, 1, 0, 7, 0, 0, 0, 0, 1, 0), 0, 0, 0);
        step("yng_w2", mk(1, 1, 0, 7, 0, 0, 0, 0, 1, 0), 0, 0, 0);
        step("yng_use", mk(1, 0, 0, 0, 7, 7, 1, 1, 1, 0), 0, 1, 1);
        // r0 never hazards; unused operands never hazard
        step("r0_load", mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 0), 0, 0, 0);
        step("r0_use", mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 0), 0, 0, 0);
        step("nouse_load", mk(1, 1, 1, 9, 0, 0, 0, 0, 1, 0), 0, 0, 0);
        step("nouse_use", mk(1, 0, 0, 0, 9, 9, 0, 0, 1, 0), 0, 0, 0);
        // Flush beats hazard and inserts a bubble (r11 writer is killed)
        step("fl_load", mk(1, 1, 1, 10, 0, 0, 0, 0, 1, 0), 0, 0, 0);
        step("fl_kill", mk(1, 1, 0, 11, 10, 0, 1, 0, 1, 1), 0, 0, 0);
        step("fl_after", mk(1, 1, 0, 16, 10, 11, 1, 1, 1, 0), 0, 2, 0);
        // Hold during load-use: everything frozen while advance=0
        step("hold_load", mk(1, 1, 1, 12, 16, 0, 1, 0, 1, 0), 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step("hold_freeze", mk(1, 1, 0, 15, 12, 0, 1, 0, 0, 0), 1, 1, 0);
        end
        step("hold_go", mk(1, 1, 0, 15, 12, 0, 1, 0, 1, 0), 1, 0, 0);
        step("hold_fwd", mk(1, 1, 0, 15, 12, 0, 1, 0, 1, 0), 0, 2, 0);
        step("rst_load", mk(1, 1, 1, 13, 15, 0, 1, 0, 1, 0), 0, 1, 0);

        // Asynchronous reset in the middle of a stall
        drive(mk(1, 0, 0, 0, 13, 0, 1, 0, 1, 0));
        @(negedge CLK);
        chk("mr.stall_pre", stall, 1);
        #1 RST = 1'b1;
        #1;
        chk("mr.stall", stall, 0);
        chk("mr.fwd1", fwd_sel1, 0);
        chk("mr.fwd2", fwd_sel2, 0);
        chk("mr.cnt", stall_count, 0);
        chk("mr.cnt_s", stall_count_b, 0);
        cnt_exp   = 16'd0;
        cnt_exp_s = 3'd0;
        @(posedge CLK);
        #1 RST = 1'b0;
        step("mr_after", mk(1, 0, 0, 0, 13, 0, 1, 0, 1, 0), 0, 0, 0);

        // Repeated load-use stalls drive the 3-bit counter into saturation
        for (int k = 0; k < 9; k++) begin
            step("sat_load", mk(1, 1, 1, 14, 0, 0, 0, 0, 1, 0), 0, 0, 0);
            step("sat_stall", mk(1, 0, 0, 0, 14, 0, 1, 0, 1, 0), 1, 0, 0);
        end
        chk("sat.final_cnt", stall_count, 9);
        chk("sat.final_cnt_s", stall_count_b, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
